fpadd_arbiter: RTL

FPADD_ARBITER -- requirements
Module: fpadd_arbiter

---
 rtl/fpadd_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/fpadd_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fpadd_pkg.sv
// Shared constants for the fpadd arbiter: operand width, op encodings and the
// default adder latency, plus the negative-zero squash applied to operands.
package fpadd_pkg;

    localparam int FP_W            = 32;
    localparam int ADD_LAT_DEFAULT = 7;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } fp_op_e;

    // -0.0 is folded to +0.0 so the adder never has to care about zero sign.
    function automatic logic [FP_W-1:0] squash_neg_zero(input logic [FP_W-1:0] x);
        return (x[FP_W-2:0] == '0) ? '0 : x;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: the first set request at or after ptr
// (wrapping) wins; the result is one-hot or zero.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic found;

    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                grant[(int'(ptr) + k) % N] = 1'b1;
                found                      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpadd_arbiter.sv
// Shares one fixed-latency fpadd among N_REQ requesters: round-robin issue,
// a tag shift register that routes each result back to its requester.
module fpadd_arbiter
    import fpadd_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int ADD_LAT = ADD_LAT_DEFAULT,
    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CNT_W   = $clog2(ADD_LAT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [FP_W*N_REQ-1:0] req_a,
    input  logic [FP_W*N_REQ-1:0] req_b,
    input  logic [N_REQ-1:0]      req_op,
    output logic [N_REQ-1:0]      req_grant,
    output logic [FP_W-1:0]       add_a,
    output logic [FP_W-1:0]       add_b,
    output logic                  add_op,
    input  logic [FP_W-1:0]       add_result,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]       rsp_data,
    output logic [CNT_W-1:0]      inflight,
    output logic                  idle
);

    logic [IDX_W-1:0] ptr;
    logic [N_REQ-1:0] arb_req;
    logic             grant_any;
    logic [IDX_W-1:0] grant_idx;

    logic [ADD_LAT-1:0] tag_valid;
    logic [IDX_W-1:0]   tag_idx [ADD_LAT];
    logic               retire;
    logic               rsp_fire;

    // Nothing may issue during reset or clear, so the selector sees no requests.
    assign arb_req = (rst || clear) ? '0 : req_valid;

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (IDX_W)
    ) u_rr (
        .req   (arb_req),
        .ptr   (ptr),
        .grant (req_grant)
    );

    always_comb begin
        grant_any = |req_grant;
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_grant[i]) grant_idx = IDX_W'(i);
        end
    end

    always_comb begin
        add_a  = '0;
        add_b  = '0;
        add_op = OP_ADD;
        if (grant_any) begin
            add_a  = squash_neg_zero(req_a[int'(grant_idx)*FP_W +: FP_W]);
            add_b  = squash_neg_zero(req_b[int'(grant_idx)*FP_W +: FP_W]);
            add_op = req_op[grant_idx];
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= '0;
        end else if (clear) begin
            tag_valid <= '0;
        end else begin
            for (int s = ADD_LAT - 1; s > 0; s--) tag_valid[s] <= tag_valid[s-1];
            tag_valid[0] <= grant_any;
        end
    end

    // NOTE: the index array has no reset; it is only ever read when the
    // matching valid bit is set, and that bit is reset.
    always_ff @(posedge clk) begin
        for (int s = ADD_LAT - 1; s > 0; s--) tag_idx[s] <= tag_idx[s-1];
        tag_idx[0] <= grant_idx;
    end

    assign retire   = tag_valid[ADD_LAT-1];
    assign rsp_fire = retire && !clear;

    always_comb begin
        rsp_valid = '0;
        if (rsp_fire) rsp_valid[tag_idx[ADD_LAT-1]] = 1'b1;
    end

    assign rsp_data = rsp_fire ? add_result : '0;

    // A grant and a retirement in the same cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else if (clear) begin
            inflight <= '0;
        end else if (grant_any && !retire) begin
            inflight <= inflight + 1'b1;
        end else if (!grant_any && retire) begin
            inflight <= inflight - 1'b1;
        end
    end

    assign idle = (inflight == '0) && (req_valid == '0);

endmodule
